// File: rtl/pkt_disassembler.sv
// rtl/pkt_disassembler.sv - SpiNNaker multicast packet checker and event-key extractor
//
// Purpose:
//    Receive-side counterpart of the multicast packet assembler. Accepts
//    72-bit SpiNNaker packets ([71:40] payload, [39:8] key, [7:0] header),
//    checks odd parity and packet type, applies a key mask/value filter and
//    forwards the key of every surviving multicast packet as a 32-bit event.
//    Dropped packets are counted in three saturating counters.
//
//    Stage 1 registers the accepted packet and classifies it. Stage 2 is an
//    output register plus one park (skid) register, so pkt_rdy_out is fully
//    registered and never depends combinationally on evt_rdy_in.
//
// Ports:
//    clk                 clock
//    reset               asynchronous, active-high reset
//    filt_msk_in         key filter mask (0 = accept every key)
//    filt_val_in         key filter match value
//    cnt_clr_in          synchronous clear of all counters (wins over increments)
//    pkt_data_in         incoming packet
//    pkt_vld_in          packet valid
//    pkt_rdy_out         packet ready (registered)
//    evt_data_out        extracted key
//    evt_pld_out         payload travelling with the key (optional)
//    evt_pld_flg_out     payload-present flag hdr[1] (optional)
//    evt_vld_out         event valid
//    evt_rdy_in          event ready
//    par_err_cnt_out     parity-error count
//    type_drop_cnt_out   non-multicast packet count
//    filt_drop_cnt_out   filtered-out multicast count
//
// Configuration:
//    PKT_DISASSEMBLER_PLD_EN  when defined, adds evt_pld_out / evt_pld_flg_out

module pkt_disassembler #(
   parameter int PACKET_BITS = 72,
   parameter int CNT_BITS    = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [31:0]            filt_msk_in,
   input  logic [31:0]            filt_val_in,
   input  logic                   cnt_clr_in,
   input  logic [PACKET_BITS-1:0] pkt_data_in,
   input  logic                   pkt_vld_in,
   output logic                   pkt_rdy_out,
   output logic [31:0]            evt_data_out,
`ifdef PKT_DISASSEMBLER_PLD_EN
   output logic [31:0]            evt_pld_out,
   output logic                   evt_pld_flg_out,
`endif
   output logic                   evt_vld_out,
   input  logic                   evt_rdy_in,
   output logic [CNT_BITS-1:0]    par_err_cnt_out,
   output logic [CNT_BITS-1:0]    type_drop_cnt_out,
   output logic [CNT_BITS-1:0]    filt_drop_cnt_out
);

   // Event word carried through stage 2: key, optionally {flag, payload, key}.
`ifdef PKT_DISASSEMBLER_PLD_EN
   localparam int EVT_BITS = 65;
`else
   localparam int EVT_BITS = 32;
`endif

   localparam int CNT_PAR  = 0;
   localparam int CNT_TYPE = 1;
   localparam int CNT_FILT = 2;

   // ---------------------------------------------------------------
   // Stage 1: accepted packet and its classification
   // ---------------------------------------------------------------
   logic                   s1_vld_q, s1_vld_d;
   logic [PACKET_BITS-1:0] s1_pkt_q, s1_pkt_d;

   logic [7:0]             s1_hdr;
   logic [31:0]            s1_key;
   logic [31:0]            s1_pld;
   logic                   s1_par_ok;
   logic                   s1_is_mc;
   logic                   s1_filt_ok;
   logic                   s1_par_drop;
   logic                   s1_type_drop;
   logic                   s1_filt_drop;
   logic                   s1_fwd;
   logic [EVT_BITS-1:0]    s1_evt;

   assign s1_hdr = s1_pkt_q[7:0];
   assign s1_key = s1_pkt_q[39:8];
   assign s1_pld = s1_pkt_q[71:40];

   // Odd parity over header and key; payload only takes part when hdr[1] says
   // it is present.
   assign s1_par_ok  = ^{s1_hdr, s1_key, (s1_pld & {32{s1_hdr[1]}})};
   assign s1_is_mc   = (s1_hdr[7:6] == 2'b00);
   assign s1_filt_ok = ((s1_key & filt_msk_in) == (filt_val_in & filt_msk_in));

   // Priority classification: exactly one outcome per valid packet.
   assign s1_par_drop  = s1_vld_q && !s1_par_ok;
   assign s1_type_drop = s1_vld_q &&  s1_par_ok && !s1_is_mc;
   assign s1_filt_drop = s1_vld_q &&  s1_par_ok &&  s1_is_mc && !s1_filt_ok;
   assign s1_fwd       = s1_vld_q &&  s1_par_ok &&  s1_is_mc &&  s1_filt_ok;

`ifdef PKT_DISASSEMBLER_PLD_EN
   assign s1_evt = {s1_hdr[1], (s1_hdr[1] ? s1_pld : 32'h0), s1_key};
`else
   assign s1_evt = s1_key;
`endif

   // ---------------------------------------------------------------
   // Stage 2: output register plus park register
   // ---------------------------------------------------------------
   logic                out_vld_q, out_vld_d;
   logic [EVT_BITS-1:0] out_q, out_d;
   logic                park_vld_q, park_vld_d;
   logic [EVT_BITS-1:0] park_q, park_d;
   logic                pkt_rdy_q, pkt_rdy_d;

   logic                evt_pop;
   logic                pkt_hs;
   logic                s1_hold;

   always_comb begin
      out_vld_d  = out_vld_q;
      out_d      = out_q;
      park_vld_d = park_vld_q;
      park_d     = park_q;
      s1_vld_d   = s1_vld_q;
      s1_pkt_d   = s1_pkt_q;

      evt_pop = out_vld_q && evt_rdy_in;
      pkt_hs  = pkt_vld_in && pkt_rdy_q;

      if (park_vld_q) begin
         // Parked event is always older than stage 1, so it moves first; a
         // forwardable stage-1 event refills the park slot behind it.
         if (evt_pop) begin
            out_d      = park_q;
            park_vld_d = s1_fwd;
            if (s1_fwd) begin
               park_d = s1_evt;
            end
         end
      end else if (out_vld_q && !evt_pop) begin
         // Output stalled: catch the stage-1 event in the park register.
         if (s1_fwd) begin
            park_vld_d = 1'b1;
            park_d     = s1_evt;
         end
      end else begin
         out_vld_d = s1_fwd;
         if (s1_fwd) begin
            out_d = s1_evt;
         end
      end

      // Stage 1 can only be blocked when both stage-2 slots are occupied and
      // nothing leaves; dropped packets never block.
      s1_hold = s1_fwd && park_vld_q && !evt_pop;

      if (pkt_hs) begin
         s1_vld_d = 1'b1;
         s1_pkt_d = pkt_data_in;
      end else if (!s1_hold) begin
         s1_vld_d = 1'b0;
      end

      // Drop ready while the park slot is filling or full, and come back only
      // once it has been empty for a full cycle. Ready high therefore
      // guarantees stage 1 will be free at the accepting edge.
      pkt_rdy_d = !park_vld_d && !park_vld_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_vld_q   <= 1'b0;
         s1_pkt_q   <= '0;
         out_vld_q  <= 1'b0;
         out_q      <= '0;
         park_vld_q <= 1'b0;
         park_q     <= '0;
         pkt_rdy_q  <= 1'b0;
      end else begin
         s1_vld_q   <= s1_vld_d;
         s1_pkt_q   <= s1_pkt_d;
         out_vld_q  <= out_vld_d;
         out_q      <= out_d;
         park_vld_q <= park_vld_d;
         park_q     <= park_d;
         pkt_rdy_q  <= pkt_rdy_d;
      end
   end

   // ---------------------------------------------------------------
   // Saturating drop counters, one edge after classification
   // ---------------------------------------------------------------
   logic [2:0]          cnt_inc;
   logic [CNT_BITS-1:0] cnt_q [3];
   logic [CNT_BITS-1:0] cnt_d [3];

   assign cnt_inc[CNT_PAR]  = s1_par_drop;
   assign cnt_inc[CNT_TYPE] = s1_type_drop;
   assign cnt_inc[CNT_FILT] = s1_filt_drop;

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         cnt_d[i] = cnt_q[i];
         if (cnt_clr_in) begin
            // A coincident increment is intentionally lost.
            cnt_d[i] = '0;
         end else if (cnt_inc[i] && (cnt_q[i] != {CNT_BITS{1'b1}})) begin
            cnt_d[i] = cnt_q[i] + CNT_BITS'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 3; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // ---------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------
   assign pkt_rdy_out       = pkt_rdy_q;
   assign evt_vld_out       = out_vld_q;
   assign evt_data_out      = out_q[31:0];
`ifdef PKT_DISASSEMBLER_PLD_EN
   assign evt_pld_out       = out_q[63:32];
   assign evt_pld_flg_out   = out_q[64];
`endif
   assign par_err_cnt_out   = cnt_q[CNT_PAR];
   assign type_drop_cnt_out = cnt_q[CNT_TYPE];
   assign filt_drop_cnt_out = cnt_q[CNT_FILT];

endmodule

// File: tb/tb_pkt_disassembler.sv
// tb/tb_pkt_disassembler.sv - scoreboard testbench for pkt_disassembler
`timescale 1ns/1ps
module tb_pkt_disassembler;

   localparam int CNT_BITS = 4;
   localparam int CNT_MAX  = (1 << CNT_BITS) - 1;

   logic                clk = 1'b0;
   logic                reset;
   logic [31:0]         filt_msk_in;
   logic [31:0]         filt_val_in;
   logic                cnt_clr_in;
   logic [71:0]         pkt_data_in;
   logic                pkt_vld_in;
   logic                pkt_rdy_out;
   logic [31:0]         evt_data_out;
`ifdef PKT_DISASSEMBLER_PLD_EN
   logic [31:0]         evt_pld_out;
   logic                evt_pld_flg_out;
`endif
   logic                evt_vld_out;
   logic                evt_rdy_in;
   logic [CNT_BITS-1:0] par_err_cnt_out;
   logic [CNT_BITS-1:0] type_drop_cnt_out;
   logic [CNT_BITS-1:0] filt_drop_cnt_out;

   pkt_disassembler #(.PACKET_BITS(72), .CNT_BITS(CNT_BITS)) dut (
      .clk               (clk),
      .reset             (reset),
      .filt_msk_in       (filt_msk_in),
      .filt_val_in       (filt_val_in),
      .cnt_clr_in        (cnt_clr_in),
      .pkt_data_in       (pkt_data_in),
      .pkt_vld_in        (pkt_vld_in),
      .pkt_rdy_out       (pkt_rdy_out),
      .evt_data_out      (evt_data_out),
`ifdef PKT_DISASSEMBLER_PLD_EN
      .evt_pld_out       (evt_pld_out),
      .evt_pld_flg_out   (evt_pld_flg_out),
`endif
      .evt_vld_out       (evt_vld_out),
      .evt_rdy_in        (evt_rdy_in),
      .par_err_cnt_out   (par_err_cnt_out),
      .type_drop_cnt_out (type_drop_cnt_out),
      .filt_drop_cnt_out (filt_drop_cnt_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] key;
      logic [31:0] pld;
      logic        flg;
      int          t_acc;
   } exp_t;

   exp_t        exp_q[$];
   int          n_chk = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          m_par, m_typ, m_flt;
   logic        p_par, p_typ, p_flt;
   logic        stall_prev;
   logic [31:0] stall_data;
   int          n_acc, n_del;
   int          rdy_low_cnt = 0;
   logic        lat_mode = 1'b0;
   logic [5:0]  rdy_pat;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [71:0] mk_pkt(input logic [31:0] pld, input logic [31:0] key,
                                          input logic [7:0] hdr);
      logic [7:0] h;
      h    = {hdr[7:1], 1'b0};
      h[0] = ~(^h ^ ^key ^ (h[1] ? ^pld : 1'b0));
      return {pld, key, h};
   endfunction

   function automatic logic par_good(input logic [71:0] p);
      return (^p[7:0] ^ ^p[39:8] ^ (p[1] ? ^p[71:40] : 1'b0)) == 1'b1;
   endfunction

   function automatic int sat(input int v);
      return (v >= CNT_MAX) ? CNT_MAX : v + 1;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard/monitor, sampled on the falling edge.
   always @(negedge clk) begin
      exp_t        e;
      logic [71:0] p;
      if (reset) begin
         exp_q.delete();
         m_par = 0; m_typ = 0; m_flt = 0;
         p_par = 1'b0; p_typ = 1'b0; p_flt = 1'b0;
         stall_prev = 1'b0; stall_data = '0;
         n_acc = 0; n_del = 0;
      end else begin
         // Counters move one edge after classification; a clear wins.
         if (cnt_clr_in) begin
            m_par = 0; m_typ = 0; m_flt = 0;
         end else begin
            if (p_par) m_par = sat(m_par);
            if (p_typ) m_typ = sat(m_typ);
            if (p_flt) m_flt = sat(m_flt);
         end
         p_par = 1'b0; p_typ = 1'b0; p_flt = 1'b0;

         if (stall_prev && evt_vld_out)
            chk("hold_stable", evt_data_out, stall_data);
         stall_prev = evt_vld_out && !evt_rdy_in;
         stall_data = evt_data_out;

         if (evt_vld_out && evt_rdy_in) begin
            n_del++;
            if (exp_q.size() == 0) begin
               chk("spurious_evt_qsize", 32'(exp_q.size()), 32'd1);
            end else begin
               e = exp_q.pop_front();
               chk("evt_key", evt_data_out, e.key);
`ifdef PKT_DISASSEMBLER_PLD_EN
               chk("evt_pld", evt_pld_out, e.pld);
               chk("evt_flg", 32'(evt_pld_flg_out), 32'(e.flg));
`endif
               if (lat_mode) chk("latency", 32'(cyc - e.t_acc), 32'd1);
            end
         end

         if (pkt_vld_in && !pkt_rdy_out) rdy_low_cnt++;

         if (pkt_vld_in && pkt_rdy_out) begin
            p = pkt_data_in;
            if (!par_good(p)) p_par = 1'b1;
            else if (p[7:6] != 2'b00) p_typ = 1'b1;
            else if ((p[39:8] & filt_msk_in) != (filt_val_in & filt_msk_in)) p_flt = 1'b1;
            else begin
               e.key   = p[39:8];
               e.flg   = p[1];
               e.pld   = p[1] ? p[71:40] : 32'h0;
               e.t_acc = cyc + 1;
               exp_q.push_back(e);
               n_acc++;
            end
         end

         if ((n_acc - n_del) > 3)
            chk("inflight_max3", 32'(n_acc - n_del), 32'd3);
      end
   end

   task automatic send_pkt(input logic [71:0] p);
      int n;
      n = 0;
      pkt_data_in = p;
      pkt_vld_in  = 1'b1;
      @(negedge clk);
      while (!pkt_rdy_out && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!pkt_rdy_out) chk("send_accept_timeout", 32'(pkt_rdy_out), 32'd1);
      @(posedge clk);
      #1;
      pkt_vld_in = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic check_cnts(input string tag);
      chk({tag, "_par"},  32'(par_err_cnt_out),   32'(m_par));
      chk({tag, "_type"}, 32'(type_drop_cnt_out), 32'(m_typ));
      chk({tag, "_filt"}, 32'(filt_drop_cnt_out), 32'(m_flt));
   endtask

   task automatic pulse_clr();
      cnt_clr_in = 1'b1;
      @(posedge clk);
      #1;
      cnt_clr_in = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [71:0] bad;
      reset = 1'b1; pkt_vld_in = 1'b0; pkt_data_in = '0; evt_rdy_in = 1'b1;
      filt_msk_in = '0; filt_val_in = '0; cnt_clr_in = 1'b0;
      rdy_pat = 6'b110100;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pkt_rdy", 32'(pkt_rdy_out), 32'd0);
      chk("rst_evt_vld", 32'(evt_vld_out), 32'd0);
      chk("rst_par_cnt", 32'(par_err_cnt_out), 32'd0);
      chk("rst_type_cnt", 32'(type_drop_cnt_out), 32'd0);
      chk("rst_filt_cnt", 32'(filt_drop_cnt_out), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("rdy_before_first_edge", 32'(pkt_rdy_out), 32'd0);
      @(posedge clk);
      #1;
      chk("rdy_after_first_edge", 32'(pkt_rdy_out), 32'd1);

      // Forwarding, back-to-back, two-edge latency
      lat_mode = 1'b1;
      send_pkt({32'h0, 32'h0000_0001, 8'h00});
      send_pkt({32'h0, 32'h0000_0003, 8'h01});
      drain();
      lat_mode = 1'b0;
      check_cnts("fwd");
      chk("fwd_par_zero", 32'(par_err_cnt_out), 32'd0);

      // Parity errors, including one that is also the wrong type
      send_pkt({32'h0, 32'h0000_0001, 8'h01});
      drain();
      chk("par_one", 32'(par_err_cnt_out), 32'd1);
      send_pkt({32'h0, 32'h0000_0001, 8'h43});
      drain();
      chk("par_two", 32'(par_err_cnt_out), 32'd2);
      chk("par_type_untouched", 32'(type_drop_cnt_out), 32'd0);

      // Type drop
      send_pkt({32'h0, 32'h0000_0001, 8'h41});
      drain();
      chk("type_one", 32'(type_drop_cnt_out), 32'd1);
      check_cnts("type");

      // Filter
      filt_msk_in = 32'hFFFF_0000;
      filt_val_in = 32'h1234_0000;
      send_pkt({32'h0, 32'h1234_5678, 8'h00});
      send_pkt({32'h0, 32'h4321_0000, 8'h00});
      drain();
      chk("filt_one", 32'(filt_drop_cnt_out), 32'd1);
      check_cnts("filt");
      filt_msk_in = 32'h0;
      filt_val_in = 32'h0;

      // Clear on its own
      pulse_clr();
      #1;
      check_cnts("clr");
      chk("clr_type_zero", 32'(type_drop_cnt_out), 32'd0);

      // Backpressure: 8 packets with evt_rdy_in toggling 0,0,1,0,1,1,...
      fork
         begin
            for (int i = 0; i < 8; i++)
               send_pkt(mk_pkt($urandom, 32'hA000_0000 + 32'(i), (i % 2 == 1) ? 8'h02 : 8'h00));
         end
         begin
            for (int c = 0; c < 40; c++) begin
               evt_rdy_in = rdy_pat[c % 6];
               @(posedge clk);
               #1;
            end
            evt_rdy_in = 1'b1;
         end
      join
      drain();
      chk("bp_rdy_dropped", 32'(rdy_low_cnt > 0), 32'd1);
      check_cnts("bp");

      // Saturation at CNT_MAX
      bad = mk_pkt(32'h5, 32'h77, 8'h02) ^ 72'h1;
      for (int i = 0; i < 20; i++) send_pkt(bad);
      drain();
      chk("par_saturated", 32'(par_err_cnt_out), 32'(CNT_MAX));
      check_cnts("sat");

      // Clear coincident with an increment: clear wins
      send_pkt(bad);
      pulse_clr();
      drain();
      chk("clr_wins", 32'(par_err_cnt_out), 32'd0);
      check_cnts("clr_coinc");

      // Reset mid-stream discards everything in flight
      evt_rdy_in = 1'b0;
      send_pkt(mk_pkt(32'h0, 32'hBEEF_0001, 8'h00));
      send_pkt(mk_pkt(32'h0, 32'hBEEF_0002, 8'h00));
      send_pkt({32'h0, 32'h0000_0001, 8'h01});
      repeat (2) @(posedge clk);
      #1;
      chk("pre_rst_vld", 32'(evt_vld_out), 32'd1);
      reset = 1'b1;
      #1;
      chk("mid_rst_evt_vld", 32'(evt_vld_out), 32'd0);
      chk("mid_rst_pkt_rdy", 32'(pkt_rdy_out), 32'd0);
      chk("mid_rst_par_cnt", 32'(par_err_cnt_out), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      evt_rdy_in = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_rdy", 32'(pkt_rdy_out), 32'd1);
      send_pkt(mk_pkt(32'h0, 32'hCAFE_0042, 8'h00));
      drain();
      chk("post_rst_no_stale", 32'(n_del), 32'd1);
      check_cnts("post_rst");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/pkt_disassembler.md
Name: pkt_disassembler

Overview:
- Receive-side counterpart of the multicast packet assembler: accepts 72-bit SpiNNaker packets, checks them, and extracts 32-bit event keys for the host/peripheral event path.
- Checks parity and packet type, applies a key mask/value filter, and keeps saturating error and drop counters.
- Two-stage pipeline, no combinational ready path from the event side back to the packet side.

Parameters:
- PACKET_BITS, 72, packet width. Fixed format: [71:40] payload, [39:8] key, [7:0] header.
- CNT_BITS, 16, width of each statistics counter.

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- filt_msk_in  input  32  key filter mask
- filt_val_in  input  32  key filter match value
- cnt_clr_in  input  1  synchronous clear of all counters
- pkt_data_in  input  PACKET_BITS  incoming packet
- pkt_vld_in  input  1  packet valid
- pkt_rdy_out  output  1  packet ready (registered)
- evt_data_out  output  32  extracted key
- evt_vld_out  output  1  event valid
- evt_rdy_in  input  1  event ready
- par_err_cnt_out  output  CNT_BITS  parity-error count
- type_drop_cnt_out  output  CNT_BITS  non-MC packet count
- filt_drop_cnt_out  output  CNT_BITS  filtered-out MC count

Behaviour:
- Reset values: pkt_rdy_out=0, evt_vld_out=0, all counters=0. evt_data_out is don't-care.
- Ready after reset: pkt_rdy_out goes to 1 at the first clock edge after reset deasserts.
- Reset mid-operation: all in-flight events are discarded.
- Header fields: hdr[7:6] type (2'b00 = multicast), hdr[1] payload-present, hdr[0] parity.
- Parity rule: XOR of hdr[7:0], key[31:0] and, if hdr[1]=1, payload[31:0] must equal 1 (odd parity). If hdr[1]=0, payload bits are excluded.
- Classification, in priority order; exactly one outcome per packet:
  - Parity fail → drop, increment par_err_cnt_out.
  - Type != 00 → drop, increment type_drop_cnt_out.
  - (key & filt_msk_in) != (filt_val_in & filt_msk_in) → drop, increment filt_drop_cnt_out.
  - Otherwise forward the key as an event.
- Filter bypass: filt_msk_in=0 passes every valid MC packet.
- Pipeline:
  - Stage 1: registers the accepted packet and classifies it.
  - Stage 2: output register plus one park (skid) register.
  - Handshake at edge t (pkt_vld_in && pkt_rdy_out) → evt_vld_out high after edge t+1 if evt_rdy_in is high.
  - Dropped packets consume a stage-1 slot but never reach the output.
- Flow control:
  - Throughput is one packet per cycle while evt_rdy_in=1.
  - When evt_vld_out && !evt_rdy_in and a forwardable event arrives from stage 1, it is parked.
  - pkt_rdy_out deasserts at the next edge while the park register is full or filling.
  - pkt_rdy_out reasserts the edge after the park register drains.
  - No event is lost, duplicated or reordered under any evt_rdy_in pattern.
- Output stability: evt_data_out holds stable while evt_vld_out && !evt_rdy_in.
- Config timing: filt_* inputs are sampled in stage 1. Software changes them only while idle; a mid-stream change affects packets classified after the change.
- Counters: saturate at all-ones. Counters update one edge after classification.
- cnt_clr_in: clears all counters at the next edge. If a clear and an increment coincide, the clear wins and that increment is lost.

Optional Feature:
- Macro: PKT_DISASSEMBLER_PLD_EN
- When defined:
  - Adds output ports evt_pld_out[31:0] and evt_pld_flg_out.
  - They travel with evt_data_out through both stages, including the park register, under the same valid/ready.
  - evt_pld_flg_out = hdr[1]. evt_pld_out = payload when hdr[1]=1, else 0.
  - Reset value of evt_pld_flg_out = 0.
- When undefined: the ports are absent and payload is used only for the parity check.

Test Plan:
- Forwarding, back-to-back:
  - Stimulus: filt_msk=0, evt_rdy_in=1, packets {32'h0,32'h0000_0001,8'h00} then {32'h0,32'h0000_0003,8'h01}.
  - Response: keys 0x1 and 0x3 out on consecutive cycles, 2-edge latency, all counters 0.
- Parity error:
  - Stimulus: {32'h0,32'h0000_0001,8'h01}.
  - Response: no event, par_err_cnt=1.
  - With hdr 8'h43 (parity bad, type also bad): par_err_cnt increments, type_drop_cnt unchanged.
- Type drop:
  - Stimulus: {32'h0,32'h0000_0001,8'h41} (P2P, parity good).
  - Response: no event, type_drop_cnt=1.
- Filter:
  - Stimulus: filt_msk=32'hFFFF_0000, filt_val=32'h1234_0000; keys 0x1234_5678 (hdr 8'h00) and 0x4321_0000 (hdr 8'h00).
  - Response: only 0x1234_5678 emitted, filt_drop_cnt=1.
- Backpressure:
  - Stimulus: 8 valid packets streamed with evt_rdy_in toggling 0,0,1,0,1,1...
  - Response: all 8 keys delivered in order, none lost or duplicated.
  - pkt_rdy_out drops within one edge of the park register filling.
  - evt_data_out holds stable while stalled.
- Saturation, clear, reset:
  - Stimulus: CNT_BITS=4, 20 bad-parity packets.
  - Response: par_err_cnt=15. cnt_clr_in coincident with a bad packet → 0. Reset mid-stream → evt_vld_out=0, pkt_rdy_out=0.
